// File: rtl/obi_pkg.sv
// Minimal OBI configuration and channel types used by the user-domain managers.
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [0:0]  aid;
    logic [31:0] wdata;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;

endpackage

// File: rtl/obi_string_streamer.sv
// OBI read manager that walks a NUL-terminated string in a word-addressed ROM
// and streams its bytes, least-significant byte of each word first, over a
// valid/ready byte interface. One read is outstanding at most.
module obi_string_streamer #(
  parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter logic [31:0]       BaseAddr  = 32'h0,
  parameter int unsigned       MaxWords  = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output obi_req_t   obi_req_o,
  input  obi_rsp_t   obi_rsp_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int unsigned     AddrW   = ObiCfg.AddrWidth;
  localparam int unsigned     IdxW    = $clog2(MaxWords + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(MaxWords);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    DONE
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [31:0]       word_q;
  logic              req_q;
  logic [AddrW-1:0]  addr_q;
  logic [7:0]        byte_q;
  logic              byte_vld_q;
  logic              done_q;
  logic              err_q;

  logic [IdxW-1:0]   word_idx_nxt;
  logic [7:0]        byte_nxt;
  logic              unused_rsp;

  // Byte address of string word idx.
  function automatic logic [AddrW-1:0] word_addr(input logic [IdxW-1:0] idx);
    return AddrW'(BaseAddr) + (AddrW'(idx) << 2);
  endfunction

  // Byte lane idx of a word, lane 0 being the least-significant byte.
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

  // Next word index and the byte that follows the one currently presented.
  always_comb begin
    word_idx_nxt = word_idx_q + 1'b1;
    byte_nxt     = pick_byte(word_q, byte_idx_q + 2'd1);
  end

  // Run controller: fetch a word, drain its bytes, stop on NUL, error or word limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= REQ;
            err_q      <= 1'b0;
            word_idx_q <= '0;
            req_q      <= 1'b1;
            addr_q     <= word_addr('0);
          end
        end
        REQ: begin
          if (obi_rsp_i.gnt) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (obi_rsp_i.rvalid) begin
            if (obi_rsp_i.r.err) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              byte_idx_q <= '0;
              byte_q     <= obi_rsp_i.r.rdata[7:0];
              byte_vld_q <= (obi_rsp_i.r.rdata[7:0] != 8'h00);
              state_q    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!byte_vld_q) begin
            // Presented byte is the terminator: finish without a handshake.
            byte_q  <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (byte_ready_i) begin
            if (byte_idx_q != 2'd3) begin
              byte_idx_q <= byte_idx_q + 2'd1;
              byte_q     <= byte_nxt;
              byte_vld_q <= (byte_nxt != 8'h00);
            end else begin
              byte_q     <= '0;
              byte_vld_q <= 1'b0;
              word_idx_q <= word_idx_nxt;
              if (word_idx_nxt == LastIdx) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                req_q   <= 1'b1;
                addr_q  <= word_addr(word_idx_nxt);
                state_q <= REQ;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Response word held for draining; its contents are never observed before capture.
  always_ff @(posedge clk_i) begin
    if (state_q == WAIT && obi_rsp_i.rvalid && !obi_rsp_i.r.err) begin
      word_q <= obi_rsp_i.r.rdata;
    end
  end

  // Read-only request: constant write enable, byte enables, id and write data.
  always_comb begin
    obi_req_o        = '0;
    obi_req_o.req    = req_q;
    obi_req_o.a.addr = addr_q;
    obi_req_o.a.we   = 1'b0;
    obi_req_o.a.be   = 4'hF;
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_vld_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;

  assign unused_rsp = ^obi_rsp_i.r.rid;

endmodule

// File: tb/tb_obi_string_streamer.sv
// Directed bench for obi_string_streamer with a word ROM responder and a byte sink.
module tb_obi_string_streamer;
  import obi_pkg::*;

  localparam logic [31:0] Base = 32'h0000_0100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       byte_ready = 1'b0;
  obi_req_t   obi_req;
  obi_rsp_t   obi_rsp = '0;
  logic [7:0] byte_o;
  logic       byte_valid;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  // ROM model and responder knobs
  logic [31:0] mem [2];
  int          gnt_delay_w1 = 0;
  int          rsp_delay = 0;
  bit          err_w1 = 1'b0;
  int          reads = 0;
  logic [31:0] addr_log [$];
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;
  bit          pend_err = 1'b0;
  int          gnt_wait = 0;

  // Sink state
  int          ready_mode = 0;
  logic [7:0]  got [$];
  int          dones = 0;
  bit          held = 1'b0;
  logic [7:0]  held_byte = '0;

  logic [7:0]  exp_basic [$];
  logic [7:0]  exp_word0 [$];
  logic [7:0]  exp_nonul [$];

  obi_string_streamer #(
    .ObiCfg   (ObiDefaultConfig),
    .obi_req_t(obi_req_t),
    .obi_rsp_t(obi_rsp_t),
    .BaseAddr (Base),
    .MaxWords (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .obi_req_o   (obi_req),
    .obi_rsp_i   (obi_rsp),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid),
    .byte_ready_i(byte_ready),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // ROM subordinate: optional grant delay on word 1, configurable response latency.
  always @(negedge clk) begin : responder
    int idx;
    obi_rsp = '0;
    if (pend) begin
      if (pend_cnt == 0) begin
        obi_rsp.rvalid  = 1'b1;
        obi_rsp.r.rdata = pend_data;
        obi_rsp.r.err   = pend_err;
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (obi_req.req === 1'b1 && !pend && !rst) begin
      idx = int'((obi_req.a.addr - Base) >> 2);
      if (idx == 1 && gnt_wait < gnt_delay_w1) begin
        gnt_wait++;
      end else begin
        obi_rsp.gnt = 1'b1;
        gnt_wait    = 0;
        reads++;
        addr_log.push_back(obi_req.a.addr);
        pend      = 1'b1;
        pend_cnt  = rsp_delay;
        pend_data = (idx >= 0 && idx < 2) ? mem[idx] : 32'hDEAD_BEEF;
        pend_err  = err_w1 && (idx == 1);
      end
    end
  end

  // Byte consumer: drives ready, records accepted bytes, checks hold under backpressure.
  always @(negedge clk) begin : consumer
    byte_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    if (held) begin
      checks++;
      assert (byte_valid === 1'b1 && byte_o === held_byte) else begin
        errors++;
        $error("FAIL hold_stable observed vld=%0b byte=%02h expected vld=1 byte=%02h",
               byte_valid, byte_o, held_byte);
      end
    end
    held      = (byte_valid === 1'b1) && !byte_ready && !rst;
    held_byte = byte_o;
    if (byte_valid === 1'b1 && byte_ready && !rst) got.push_back(byte_o);
    if (done === 1'b1) dones++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] exp [$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
    end
  endtask

  task automatic chk_addr(input string tag, input int n, input logic [31:0] exp);
    chk({tag, "_logsize"}, (addr_log.size() > n) ? 1 : 0, 1);
    if (addr_log.size() > n) chk(tag, addr_log[n], exp);
  endtask

  task automatic clear_run();
    got.delete();
    addr_log.delete();
    reads = 0;
    dones = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    exp_basic = '{8'h54, 8'h2E, 8'h50, 8'h49, 8'h49, 8'h43};
    exp_word0 = '{8'h54, 8'h2E, 8'h50, 8'h49};
    exp_nonul = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41};
    mem[0] = 32'h4950_2E54;
    mem[1] = 32'h0000_4349;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", obi_req.req, 1'b0);
    chk("rst_valid", byte_valid, 1'b0);
    chk("rst_byte", byte_o, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic string, zero-wait subordinate, ready held high
    clear_run();
    pulse_start();
    wait_done("basic", 100);
    chk_bytes("basic", exp_basic);
    chk("basic_reads", reads, 2);
    chk_addr("basic_addr0", 0, Base);
    chk_addr("basic_addr1", 1, Base + 32'd4);
    chk("basic_dones", dones, 1);
    chk("basic_err", err, 1'b0);
    chk("basic_busy", busy, 1'b0);

    // Backpressure at ~30% ready
    ready_mode = 1;
    clear_run();
    pulse_start();
    wait_done("bp", 600);
    chk_bytes("bp", exp_basic);
    chk("bp_reads", reads, 2);
    chk("bp_dones", dones, 1);
    ready_mode = 0;

    // No terminator: word limit ends the run
    mem[0] = 32'h4141_4141;
    mem[1] = 32'h4141_4141;
    clear_run();
    pulse_start();
    wait_done("nonul", 100);
    repeat (10) @(negedge clk);
    chk_bytes("nonul", exp_nonul);
    chk("nonul_reads", reads, 2);
    chk("nonul_req_idle", obi_req.req, 1'b0);
    chk("nonul_dones", dones, 1);

    // Error response on word 1 after a delayed grant
    mem[0] = 32'h4950_2E54;
    mem[1] = 32'h0000_4349;
    gnt_delay_w1 = 3;
    err_w1 = 1'b1;
    clear_run();
    pulse_start();
    wait_done("error", 100);
    chk_bytes("error", exp_word0);
    chk("error_err", err, 1'b1);
    chk("error_dones", dones, 1);
    chk_addr("error_addr1", 1, Base + 32'd4);
    gnt_delay_w1 = 0;
    err_w1 = 1'b0;

    // Next start clears the sticky error
    clear_run();
    pulse_start();
    chk("errclr_err", err, 1'b0);
    chk("errclr_busy", busy, 1'b1);
    wait_done("errclr", 100);
    chk_bytes("errclr", exp_basic);

    // Reset while waiting for the word 1 response; the late response must be ignored
    rsp_delay = 6;
    clear_run();
    pulse_start();
    n = 0;
    while (reads < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reads", reads, 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req", obi_req.req, 1'b0);
    chk("midrst_valid", byte_valid, 1'b0);
    chk("midrst_byte", byte_o, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_stray_busy", busy, 1'b0);
    chk("midrst_stray_valid", byte_valid, 1'b0);
    chk("midrst_stray_bytes", got.size(), 4);
    chk("midrst_stray_dones", dones, 0);
    rsp_delay = 0;
    clear_run();
    pulse_start();
    wait_done("restart", 100);
    chk_addr("restart_addr0", 0, Base);
    chk_bytes("restart", exp_basic);

    // Start pulsed while draining has no effect
    clear_run();
    pulse_start();
    n = 0;
    while (byte_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busystart_valid_seen", byte_valid, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busystart", 100);
    repeat (10) @(negedge clk);
    chk("busystart_reads", reads, 2);
    chk("busystart_dones", dones, 1);
    chk("busystart_busy", busy, 1'b0);
    chk_bytes("busystart", exp_basic);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_string_streamer.md
Name: obi_string_streamer

Overview:
- OBI manager that reads a NUL-terminated byte string from a word-addressed read-only OBI subordinate, such as the user-domain ID ROM.
- Unpacks each 32-bit word into bytes, least-significant byte first.
- Presents the bytes on a valid/ready byte stream for a downstream consumer (UART TX FIFO, debug mailbox).
- Sits between the user-domain OBI crossbar manager port and the byte consumer.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration; DataWidth must be 32.
- obi_req_t, logic, OBI request struct type.
- obi_rsp_t, logic, OBI response struct type.
- BaseAddr, 32'h0, byte address of word 0 of the string; must be 4-byte aligned.
- MaxWords, 8, maximum words fetched per run; must be at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  start a run; sampled only in IDLE.
- obi_req_o  out  obi_req_t  OBI manager request.
- obi_rsp_i  in  obi_rsp_t  OBI manager response.
- byte_o  out  8  current string byte.
- byte_valid_o  out  1  byte_o is valid.
- byte_ready_i  in  1  consumer accepts byte.
- busy_o  out  1  run in progress (state is not IDLE).
- done_o  out  1  one-cycle pulse at end of run.
- err_o  out  1  sticky: last run ended on an OBI error; cleared on the next start.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - state IDLE; word index 0; byte index 0.
  - obi_req_o.req=0, byte_valid_o=0, byte_o=0, busy_o=0, done_o=0, err_o=0.
- States: IDLE, REQ, WAIT, DRAIN, DONE.
- IDLE -> REQ on start_i=1. This clears err_o and resets the word index to 0.
- REQ:
  - Drive req=1, a.addr=BaseAddr+4*word_idx, a.we=0, a.be=4'hF, a.aid=0, a.wdata=0.
  - Request fields stay stable while req=1 and gnt=0.
  - On gnt=1, go to WAIT; req drops the following cycle.
- WAIT:
  - On rvalid=1 with r.err=0: capture r.rdata, set byte index 0, go to DRAIN.
  - On rvalid=1 with r.err=1: set err_o, go to DONE.
  - rvalid=1 may arrive in the cycle after gnt (zero-wait subordinate). It must be handled with no lost response.
- DRAIN:
  - byte_o = captured word bits [8*bi+7 : 8*bi]; byte_valid_o=1 unless that byte is 0x00.
  - byte_o and byte_valid_o stay stable until byte_ready_i=1.
  - Byte == 0x00: the NUL terminator is not emitted; go to DONE the same cycle, without waiting for ready.
  - Accepted byte with bi<3: bi+1.
  - Accepted byte with bi=3: word_idx+1. If word_idx+1 == MaxWords, go to DONE; otherwise go to REQ.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o=1 in every state except IDLE.
- Outstanding transactions: at most one; no new request is issued before the rvalid of the previous one.
- Ignored inputs:
  - rvalid in any state other than WAIT.
  - start_i while busy.
- Throughput: one byte per cycle while byte_ready_i is held 1. Per-word overhead is at least 2 cycles (REQ + WAIT).
- Reset mid-run: immediate return to the reset state. A pending OBI response after reset is ignored, since it does not arrive in WAIT.
- word_idx width: clog2(MaxWords+1).
- Address arithmetic: ObiCfg.AddrWidth bits; wrap-around is unchecked.

Test Plan:
- Basic string: memory word0=32'h49502E54, word1=32'h00004349, zero-wait gnt/rvalid, ready tied 1, start pulse.
  -> bytes 0x54,0x2E,0x50,0x49,0x49,0x43, in order.
  -> NUL not emitted; 2 OBI reads at BaseAddr and BaseAddr+4.
  -> done_o pulses once; err_o=0.
- Backpressure: same memory, byte_ready_i random 30% duty.
  -> identical byte sequence; byte_o stable while valid&&!ready; no duplicated or dropped bytes.
- No terminator: MaxWords=2, memory all 32'h41414141.
  -> exactly 8 bytes 0x41; 2 reads; done_o pulse; no third request.
- Error: gnt delayed 3 cycles on word1, then rvalid with r.err=1.
  -> 4 bytes from word0 emitted; err_o=1 after the run; done_o pulse.
  -> next start clears err_o at the IDLE->REQ transition.
- Reset mid-run: assert rst_i during WAIT of word1.
  -> all outputs 0 asynchronously; a later stray rvalid is ignored.
  -> a fresh start re-reads from BaseAddr.
- Start while busy: pulse start_i during DRAIN.
  -> no effect; a single done_o pulse; the read count equals the words consumed.
